// File: rtl/tile_rom_pkg.sv
// Shared tile ROM definitions used by the arbiter and the platform renderer.
package tile_rom_pkg;

    localparam int unsigned ADDR_W = 11;   // {row[6:0], col[3:0]}
    localparam int unsigned DATA_W = 12;   // 4:4:4 RGB
    localparam int unsigned CNT_W  = 8;    // port-1 wait counter width

    localparam logic [DATA_W-1:0] TRANSPARENT_COLOR = 12'h6DE;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } owner_t;

    // A tile word is solid unless it is the sprite background colour.
    function automatic logic is_solid(input logic [DATA_W-1:0] word);
        return word != TRANSPARENT_COLOR;
    endfunction

endpackage

// File: rtl/tile_rom_starve_cnt.sv
// Saturating wait counter with a registered at-limit flag.
module tile_rom_starve_cnt #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register; the flag tracks the value being loaded so it matches the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            at_limit <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_limit <= (cnt_d == LIMIT_V);
        end
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Shares the single-port tile ROM between the renderer (port 0, never stalled)
// and the collision probe (port 1, served only in port-0 idle cycles).
module tile_rom_arbiter
    import tile_rom_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_valid,
    output logic [DATA_W-1:0] p0_data,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_valid,
    output logic [DATA_W-1:0] p1_data,
    output logic              p1_solid,
    output logic              p1_starved,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);

    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;

    assign p1_gnt = p1_req & ~p0_req;

    // Address mux; idle cycles replay the last driven address so the ROM bus stays quiet.
    always_comb begin
        rom_addr = addr_q;
        if (p0_req) begin
            rom_addr = p0_addr;
        end else if (p1_req) begin
            rom_addr = p1_addr;
        end
    end

    // Remember the last address actually presented to the ROM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (p0_req || p1_req) begin
            addr_q <= rom_addr;
        end
    end

    // Track which port the word arriving next cycle belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= NONE;
        end else if (p0_req) begin
            owner_q <= P0;
        end else if (p1_gnt) begin
            owner_q <= P1;
        end else begin
            owner_q <= NONE;
        end
    end

    // Route the ROM word to its owner; the other port sees zero.
    always_comb begin
        p0_valid = (owner_q == P0);
        p1_valid = (owner_q == P1);
        p0_data  = p0_valid ? rom_q : '0;
        p1_data  = p1_valid ? rom_q : '0;
        p1_solid = p1_valid && is_solid(rom_q);
    end

    // Port-1 starvation watchdog: counts consecutive denied cycles.
    tile_rom_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (p1_req & ~p1_gnt),
        .clr      (p1_gnt | ~p1_req),
        .at_limit (p1_starved)
    );

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed bench for tile_rom_arbiter with a 1-cycle-latency ROM model.
module tb_tile_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0;
    logic [10:0] p0_addr = '0;
    logic        p0_valid;
    logic [11:0] p0_data;
    logic        p1_req = 1'b0;
    logic [10:0] p1_addr = '0;
    logic        p1_gnt;
    logic        p1_valid;
    logic [11:0] p1_data;
    logic        p1_solid;
    logic        p1_starved;
    logic [10:0] rom_addr;
    logic [11:0] rom_q = '0;

    logic [11:0] rom_mem [2048];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_rom_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_valid   (p0_valid),
        .p0_data    (p0_data),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_gnt     (p1_gnt),
        .p1_valid   (p1_valid),
        .p1_data    (p1_data),
        .p1_solid   (p1_solid),
        .p1_starved (p1_starved),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q)
    );

    // Synchronous ROM: word for the address sampled at this edge appears after it.
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ROM contents: rom[i] = 3*i + 1 with a few marked words.
        for (int i = 0; i < 2048; i++) rom_mem[i] = 12'(3 * i + 1);
        rom_mem[11'h110] = 12'hF00;
        rom_mem[11'h040] = 12'h6DE;
        rom_mem[11'h041] = 12'h6DF;

        // Reset state
        #1;
        chk("rst_p0_valid", 32'(p0_valid), 0);
        chk("rst_p1_valid", 32'(p1_valid), 0);
        chk("rst_p0_data", 32'(p0_data), 0);
        chk("rst_p1_data", 32'(p1_data), 0);
        chk("rst_solid", 32'(p1_solid), 0);
        chk("rst_starved", 32'(p1_starved), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        step();
        reset_n = 1'b1;
        step();

        // Port 0 alone
        p0_req = 1'b1; p0_addr = 11'h110;
        #1;
        chk("p0_rom_addr", 32'(rom_addr), 32'h110);
        chk("p0_no_gnt", 32'(p1_gnt), 0);
        step();
        p0_req = 1'b0;
        chk("p0_valid", 32'(p0_valid), 1);
        chk("p0_data", 32'(p0_data), 32'hF00);
        chk("p0_p1_valid", 32'(p1_valid), 0);
        step();
        chk("p0_idle_valid", 32'(p0_valid), 0);
        chk("idle_rom_addr_hold", 32'(rom_addr), 32'h110);

        // Conflict: three cycles of port 0 priority, then port 1 granted
        p0_req = 1'b1; p0_addr = 11'h001;
        p1_req = 1'b1; p1_addr = 11'h002;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("conf_gnt_low", 32'(p1_gnt), 0);
            chk("conf_rom_addr", 32'(rom_addr), 32'h001);
            step();
            chk("conf_p0_valid", 32'(p0_valid), 1);
            chk("conf_p0_data", 32'(p0_data), 32'd4);
            chk("conf_p1_valid", 32'(p1_valid), 0);
        end
        p0_req = 1'b0;
        #1;
        chk("conf_gnt_high", 32'(p1_gnt), 1);
        chk("conf_p1_rom_addr", 32'(rom_addr), 32'h002);
        chk("conf_not_starved", 32'(p1_starved), 0);
        step();
        p1_req = 1'b0;
        chk("conf_p1_valid", 32'(p1_valid), 1);
        chk("conf_p1_data", 32'(p1_data), 32'd7);
        chk("conf_p0_zero", 32'(p0_data), 0);
        step();

        // Transparency: background colour then near-miss colour, back to back
        p1_req = 1'b1; p1_addr = 11'h040;
        step();
        p1_addr = 11'h041;
        chk("transp_valid", 32'(p1_valid), 1);
        chk("transp_data", 32'(p1_data), 32'h6DE);
        chk("transp_solid", 32'(p1_solid), 0);
        step();
        p1_req = 1'b0;
        chk("solid_data", 32'(p1_data), 32'h6DF);
        chk("solid_flag", 32'(p1_solid), 1);
        step();
        chk("solid_idle", 32'(p1_solid), 0);

        // Starvation with limit 4
        p0_req = 1'b1; p0_addr = 11'h010;
        p1_req = 1'b1; p1_addr = 11'h003;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("starve_%0d", k), 32'(p1_starved), (k >= 4) ? 32'd1 : 32'd0);
        end
        p0_req = 1'b0;
        #1;
        chk("starve_gnt", 32'(p1_gnt), 1);
        chk("starve_still_set", 32'(p1_starved), 1);
        step();
        p1_req = 1'b0;
        chk("starve_cleared", 32'(p1_starved), 0);
        chk("starve_p1_data", 32'(p1_data), 32'd10);
        step();

        // Back-to-back port 1 reads: 5, 6, 7
        p1_req = 1'b1; p1_addr = 11'd5;
        step();
        p1_addr = 11'd6;
        chk("b2b_v5", 32'(p1_valid), 1);
        chk("b2b_d5", 32'(p1_data), 32'd16);
        step();
        p1_addr = 11'd7;
        chk("b2b_v6", 32'(p1_valid), 1);
        chk("b2b_d6", 32'(p1_data), 32'd19);
        step();
        p1_req = 1'b0;
        chk("b2b_v7", 32'(p1_valid), 1);
        chk("b2b_d7", 32'(p1_data), 32'd22);
        step();
        chk("b2b_done", 32'(p1_valid), 0);

        // Alternation P0, P1, P0 yields valids in the same order
        p0_req = 1'b1; p0_addr = 11'd8; p1_req = 1'b1; p1_addr = 11'd9;
        step();
        p0_req = 1'b0;
        chk("alt0_p0", 32'(p0_valid), 1);
        chk("alt0_d", 32'(p0_data), 32'd25);
        step();
        p1_req = 1'b0; p0_req = 1'b1; p0_addr = 11'd10;
        chk("alt1_p1", 32'(p1_valid), 1);
        chk("alt1_d", 32'(p1_data), 32'd28);
        step();
        p0_req = 1'b0;
        chk("alt2_p0", 32'(p0_valid), 1);
        chk("alt2_d", 32'(p0_data), 32'd31);
        step();

        // Reset in the cycle after a port-1 grant
        p1_req = 1'b1; p1_addr = 11'h041;
        step();
        p1_req = 1'b0;
        chk("rmid_pre_valid", 32'(p1_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("rmid_valid", 32'(p1_valid), 0);
        chk("rmid_data", 32'(p1_data), 0);
        chk("rmid_solid", 32'(p1_solid), 0);
        step();
        reset_n = 1'b1;
        #1;
        chk("rmid_rom_addr", 32'(rom_addr), 0);
        step();
        chk("rmid_no_replay", 32'(p1_valid), 0);
        chk("rmid_p0_quiet", 32'(p0_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
